// File: rtl/s_rca_pipe.sv
// Pipelined signed ripple-carry adder: N-bit operands split into STAGES carry-chained chunks,
// N+1-bit sign-extended sum, valid/ready on both sides. Define S_RCA_PIPE_SUB_EN to add a sub port (a-b).
module s_rca_pipe #(
  parameter int unsigned N      = 24,
  parameter int unsigned STAGES = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef S_RCA_PIPE_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   s_rca_pipe_out
);

  localparam int unsigned CW   = N / STAGES;
  localparam int unsigned LAST = STAGES - 1;
  localparam int unsigned MID  = (STAGES > 1) ? STAGES - 1 : 1;

  if (N < 2 || STAGES < 1 || STAGES > N || (N % STAGES) != 0) begin : g_bad_param
    $error("s_rca_pipe: need N >= 2, 1 <= STAGES <= N and N %% STAGES == 0");
  end

  logic              en;
  logic [N-1:0]      b_eff;
  logic              cin0;
  logic [STAGES-1:0] valid_q;
  logic [N:0]        out_q;

  // Inter-stage registers: entry k feeds stage k+1.
  logic [N-1:0]      a_q     [MID];
  logic [N-1:0]      b_q     [MID];
  logic              carry_q [MID];
  logic [N:0]        sum_q   [MID];

  // Per-stage inputs and results.
  logic [N-1:0]      a_src   [STAGES];
  logic [N-1:0]      b_src   [STAGES];
  logic              c_src   [STAGES];
  logic [N:0]        s_src   [STAGES];
  logic [CW:0]       chunk   [STAGES];
  logic [N:0]        sum_d   [STAGES];
  logic              carry_d [STAGES];

`ifdef S_RCA_PIPE_SUB_EN
  always_comb begin
    b_eff = sub ? ~b : b;
    cin0  = sub;
  end
`else
  always_comb begin
    b_eff = b;
    cin0  = 1'b0;
  end
`endif

  always_comb begin
    en = !valid_q[LAST] || out_ready;
  end

  assign in_ready       = en;
  assign out_valid      = valid_q[LAST];
  assign s_rca_pipe_out = out_q;

  always_comb begin
    a_src[0] = a;
    b_src[0] = b_eff;
    c_src[0] = cin0;
    s_src[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = carry_q[k-1];
      s_src[k] = sum_q[k-1];
    end
  end

  // Each stage fills in its own CW sum bits; the last also forms the sign-extension bit.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk[k]   = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
                 + {{CW{1'b0}}, c_src[k]};
      sum_d[k]   = s_src[k];
      sum_d[k][k*CW +: CW] = chunk[k][CW-1:0];
      carry_d[k] = chunk[k][CW];
      if (k == LAST) begin
        sum_d[k][N] = a_src[k][N-1] ^ b_src[k][N-1] ^ chunk[k][CW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      out_q   <= '0;
    end else if (en) begin
      valid_q[0] <= in_valid;
      for (int unsigned k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      out_q <= sum_d[LAST];
    end
  end

  always_ff @(posedge clk) begin
    if (en) begin
      for (int unsigned k = 0; k < LAST; k++) begin
        a_q[k]     <= a_src[k];
        b_q[k]     <= b_src[k];
        carry_q[k] <= carry_d[k];
        sum_q[k]   <= sum_d[k];
      end
    end
  end

endmodule

// File: tb/tb_s_rca_pipe.sv
// Scoreboard bench for s_rca_pipe: expected sums from signed integer arithmetic, checked by a monitor.
module tb_s_rca_pipe;
  localparam int unsigned N      = 24;
  localparam int unsigned STAGES = 3;
`ifdef S_RCA_PIPE_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   dout;

  int unsigned  errors = 0;
  int unsigned  checks = 0;
  int unsigned  cyc    = 0;
  logic [N:0]   expq[$];
  int unsigned  popcyc[$];
  bit           rnd_rdy = 1'b0;

  s_rca_pipe #(.N(N), .STAGES(STAGES)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a              (a),
    .b              (b),
`ifdef S_RCA_PIPE_SUB_EN
    .sub            (sub),
`endif
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .s_rca_pipe_out (dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [N:0] model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    longint sx = longint'($signed(x));
    longint sy = longint'($signed(y));
    longint r  = s ? (sx - sy) : (sx + sy);
    return r[N:0];
  endfunction

  task automatic check(input string name, input logic [N:0] act, input logic [N:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: transfers are decided at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) expq.push_back(model(a, b, sub));
      if (out_valid && out_ready) begin
        popcyc.push_back(cyc);
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", dout);
        end else begin
          check("sum", dout, expq.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
    int unsigned w;
    w = 0;
    a = x; b = y; sub = s & HAS_SUB; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned w;
    w = 0;
    while (expq.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check(name, (N+1)'(expq.size()), '0);
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned n;
    int unsigned consec;
    logic [N:0]  hold;
    logic [N-1:0] corners [5];
    corners[0] = 24'h7FFFFF; corners[1] = 24'h800000; corners[2] = 24'hFFFFFF;
    corners[3] = 24'h000000; corners[4] = 24'h000001;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", (N+1)'(out_valid), '0);
    check("rst_out", dout, '0);
    check("rst_in_ready", (N+1)'(in_ready), (N+1)'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency and single-cycle valid pulse.
    a = 24'h7FFFFF; b = 24'h000001; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("latency", (N+1)'(n), (N+1)'(STAGES));
    check("max_pos_plus_one", dout, 25'h0800000);
    @(negedge clk);
    check("valid_one_cycle", (N+1)'(out_valid), '0);
    @(posedge clk); #1;

    send(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    send(24'h800000, 24'h800000, 1'b0);
    drain("corner_drain");

    // Back-to-back: eight results on consecutive cycles.
    popcyc.delete();
    for (int i = 0; i < 8; i++) send(N'($urandom()), N'($urandom()), 1'($urandom_range(0, 1)));
    drain("b2b_drain");
    consec = 0;
    for (int i = 1; i < popcyc.size(); i++) if (popcyc[i] == popcyc[i-1] + 1) consec++;
    check("b2b_count", (N+1)'(popcyc.size()), (N+1)'(8));
    check("b2b_consecutive", (N+1)'(consec), (N+1)'(7));

    // Stall with full pipeline.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(N'($urandom()), N'($urandom()), 1'b0);
    a = 24'h123456; b = 24'h654321; sub = 1'b0; in_valid = 1'b1;
    hold = dout;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", (N+1)'(in_ready), '0);
      check("stall_out_valid", (N+1)'(out_valid), (N+1)'(1));
      check("stall_out_hold", dout, hold);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(24'h123456, 24'h654321, 1'b0);
    drain("stall_drain");

    // Reset with results in flight.
    out_ready = 1'b0;
    for (int i = 0; i < STAGES; i++) send(N'($urandom()), N'($urandom()), 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", (N+1)'(out_valid), '0);
    check("midrst_out", dout, '0);
    check("midrst_in_ready", (N+1)'(in_ready), (N+1)'(1));
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("post_rst_no_output", (N+1)'(n), '0);
    @(posedge clk); #1;

    if (HAS_SUB) begin
      send(24'h000005, 24'h000007, 1'b1);
      drain("sub_drain");
    end

    // Random traffic with random back-pressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] x;
      logic [N-1:0] y;
      x = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom());
      y = ($urandom_range(0, 4) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom());
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
      send(x, y, 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    drain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation time got limit expected completion");
    $fatal(1, "timeout");
  end
endmodule
